// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types for the LC-3b 2-way set-associative cache.
// Revision    : 1.0
// ============================================================================
package cache_pkg;

    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [3:0]   lc3b_c_offset;
    typedef logic [127:0] lc3b_c_block;
    typedef logic [15:0]  lc3b_word;

    localparam int c_offset_w = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } cache_state_e;

    // Byte-lane merge for partial-word stores.
    function automatic lc3b_word merge_word(input lc3b_word old_w,
                                            input lc3b_word new_w,
                                            input logic [1:0] be);
        merge_word = {be[1] ? new_w[15:8] : old_w[15:8],
                      be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_if
// Description : CPU-side and physical-memory-side buses of the cache.
// Revision    : 1.0
// ============================================================================
interface cache_if;
    import cache_pkg::*;

    lc3b_word    mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    lc3b_word    mem_wdata;
    lc3b_word    mem_rdata;
    logic        mem_resp;
    lc3b_word    pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    lc3b_c_block pmem_wdata;
    lc3b_c_block pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Cache FSM: hit response, writeback/allocate sequencing, strobes.
// Revision    : 1.0
// ============================================================================
module cache_control
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_hit,
    input  logic i_victim_dirty,
    input  logic i_pmem_resp,
    output logic o_mem_resp,
    output logic o_pmem_read,
    output logic o_pmem_write,
    output logic o_ld_hit,
    output logic o_ld_miss,
    output logic o_ld_fill
);

    cache_state_e r_state;
    cache_state_e w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // pmem strobes decode from the state register only, so reset drops them at once.
    always_comb begin
        w_next       = r_state;
        o_mem_resp   = 1'b0;
        o_pmem_read  = 1'b0;
        o_pmem_write = 1'b0;
        o_ld_hit     = 1'b0;
        o_ld_miss    = 1'b0;
        o_ld_fill    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (i_hit) begin
                        o_mem_resp = 1'b1;
                        o_ld_hit   = 1'b1;
                    end else begin
                        o_ld_miss = 1'b1;
                        w_next    = i_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                o_pmem_write = 1'b1;
                if (i_pmem_resp) begin
                    w_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                o_pmem_read = 1'b1;
                if (i_pmem_resp) begin
                    o_ld_fill = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cache.sv
`default_nettype none
// ============================================================================
// Module      : cache
// Description : 2-way set-associative write-back, write-allocate unified cache.
// Revision    : 1.0
// ============================================================================
module cache
    import cache_pkg::*;
#(
    parameter int NUM_SETS  = 8,
    parameter int LINE_BITS = 128
) (
    input  logic    clk,
    input  logic    rst,
    cache_if.slave  bus
);

    localparam int c_idx_w = $clog2(NUM_SETS);
    localparam int c_tag_w = 16 - c_offset_w - c_idx_w;

    logic [LINE_BITS-1:0] r_data  [2][NUM_SETS];
    logic [c_tag_w-1:0]   r_tag   [2][NUM_SETS];
    logic [NUM_SETS-1:0]  r_valid [2];
    logic [NUM_SETS-1:0]  r_dirty [2];
    logic [NUM_SETS-1:0]  r_lru;

    logic                 r_victim;
    logic [c_tag_w-1:0]   r_req_tag;
    logic [c_idx_w-1:0]   r_req_idx;

    logic [c_tag_w-1:0]   w_tag;
    logic [c_idx_w-1:0]   w_idx;
    logic [2:0]           w_word;
    logic                 w_unused_addr_lsb;
    logic                 w_req;
    logic                 w_hit0;
    logic                 w_hit1;
    logic                 w_hit;
    logic                 w_hit_way;
    logic                 w_victim;
    logic                 w_victim_dirty;
    logic [LINE_BITS-1:0] w_hit_line;
    lc3b_word             w_hit_word;
    lc3b_word             w_merged;

    logic w_mem_resp;
    logic w_pmem_read;
    logic w_pmem_write;
    logic w_ld_hit;
    logic w_ld_miss;
    logic w_ld_fill;

    assign w_tag             = bus.mem_address[15 -: c_tag_w];
    assign w_idx             = bus.mem_address[c_offset_w +: c_idx_w];
    assign w_word            = bus.mem_address[3:1];
    assign w_unused_addr_lsb = bus.mem_address[0];
    assign w_req             = bus.mem_read | bus.mem_write;

    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hit_way = ~w_hit0;

    // Fill invalid ways first (way 0 preferred) before evicting the LRU way.
    assign w_victim       = !r_valid[0][w_idx] ? 1'b0 :
                            !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    assign w_hit_line = r_data[w_hit_way][w_idx];
    assign w_hit_word = w_hit_line[{w_word, 4'b0000} +: 16];
    assign w_merged   = merge_word(w_hit_word, bus.mem_wdata, bus.mem_byte_enable);

    cache_control u_control (
        .clk            (clk),
        .rst            (rst),
        .i_req          (w_req),
        .i_hit          (w_hit),
        .i_victim_dirty (w_victim_dirty),
        .i_pmem_resp    (bus.pmem_resp),
        .o_mem_resp     (w_mem_resp),
        .o_pmem_read    (w_pmem_read),
        .o_pmem_write   (w_pmem_write),
        .o_ld_hit       (w_ld_hit),
        .o_ld_miss      (w_ld_miss),
        .o_ld_fill      (w_ld_fill)
    );

    // Miss context is captured so the transfer survives the CPU dropping its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
            r_victim   <= 1'b0;
            r_req_tag  <= '0;
            r_req_idx  <= '0;
        end else begin
            if (w_ld_miss) begin
                r_victim  <= w_victim;
                r_req_tag <= w_tag;
                r_req_idx <= w_idx;
            end
            if (w_ld_hit) begin
                r_lru[w_idx] <= ~w_hit_way;
                if (bus.mem_write) begin
                    r_dirty[w_hit_way][w_idx] <= 1'b1;
                end
            end
            if (w_ld_fill) begin
                r_valid[r_victim][r_req_idx] <= 1'b1;
                r_dirty[r_victim][r_req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_fill) begin
            r_data[r_victim][r_req_idx] <= bus.pmem_rdata;
            r_tag[r_victim][r_req_idx]  <= r_req_tag;
        end else if (w_ld_hit && bus.mem_write) begin
            r_data[w_hit_way][w_idx][{w_word, 4'b0000} +: 16] <= w_merged;
        end
    end

    assign bus.mem_resp     = w_mem_resp;
    assign bus.mem_rdata    = w_mem_resp ? w_hit_word : '0;
    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = w_pmem_write ? {r_tag[r_victim][r_req_idx], r_req_idx, 4'b0000} :
                              w_pmem_read  ? {r_req_tag, r_req_idx, 4'b0000} : '0;
    assign bus.pmem_wdata   = w_pmem_write ? r_data[r_victim][r_req_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache
// Description : Scoreboard bench for cache with a fixed-latency memory model.
// Revision    : 1.0
// ============================================================================
module tb_cache;
    import cache_pkg::*;

    localparam int c_pmem_lat = 3;

    typedef struct packed {
        logic        chk;
        logic [15:0] data;
    } resp_t;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } pm_t;

    logic clk = 1'b0;
    logic rst;

    resp_t        resp_q[$];
    pm_t          pm_q[$];
    logic [127:0] mem [logic [15:0]];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    cache_if bus();

    cache #(
        .NUM_SETS  (8),
        .LINE_BITS (128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [127:0] c_line40 = 128'h7777_6666_5555_4444_3333_2222_BEEF_1111;

    function automatic logic [127:0] dflt_line(input logic [15:0] a);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*16 +: 16] = {a[15:4], 4'b0000} + 16'(2 * i);
        end
        return l;
    endfunction

    function automatic logic [127:0] set_word(input logic [127:0] l, input int w,
                                              input logic [15:0] v);
        logic [127:0] r;
        r = l;
        r[w*16 +: 16] = v;
        return r;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pm_push(input logic wr, input logic [15:0] addr, input logic [127:0] wd);
        pm_t e;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wd;
        pm_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the response cycle.
    task automatic cpu_req(input logic wr, input logic [15:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, input logic [15:0] exp_rd, input int exp_lat);
        resp_t e;
        int    cycles;
        e.chk  = ~wr;
        e.data = exp_rd;
        resp_q.push_back(e);
        bus.mem_address     = addr;
        bus.mem_read        = ~wr;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        cycles = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) break;
            cycles++;
            if (cycles > 50) begin
                checks++;
                errors++;
                $display("FAIL timeout: no mem_resp for addr %h got 0 expected 1", addr);
                break;
            end
        end
        check16("latency", 16'(cycles), 16'(exp_lat));
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // Response monitor: every mem_resp cycle must match the oldest expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && bus.mem_resp) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got mem_resp=1 expected 0 at addr %h", bus.mem_address);
            end else begin
                e = resp_q.pop_front();
                if (e.chk) check16("rdata", bus.mem_rdata, e.data);
            end
        end
    end

    // Physical memory model and pmem transaction monitor.
    initial begin
        logic         op;
        logic [15:0]  a;
        logic [127:0] wd;
        logic         aborted;
        pm_t          e;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && (bus.pmem_read || bus.pmem_write)) begin
                op      = bus.pmem_write;
                a       = bus.pmem_address;
                wd      = bus.pmem_wdata;
                aborted = 1'b0;
                for (int k = 0; k < c_pmem_lat - 1; k++) begin
                    @(negedge clk);
                    if (!(bus.pmem_read || bus.pmem_write)) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    check16("pmem_addr_stable", bus.pmem_address, a);
                    check16("pmem_excl", 16'(bus.pmem_read & bus.pmem_write), 16'h0);
                    checks++;
                    if (pm_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pmem: got op=%0d addr %h expected none", op, a);
                    end else begin
                        e = pm_q.pop_front();
                        check16("pmem_op", 16'(op), 16'(e.wr));
                        check16("pmem_addr", a, e.addr);
                        if (op) check128("pmem_wdata", wd, e.wdata);
                    end
                    if (op) begin
                        mem[a] = wd;
                    end else begin
                        bus.pmem_rdata = mem.exists(a) ? mem[a] : dflt_line(a);
                    end
                    bus.pmem_resp = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.pmem_resp = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst                 = 1'b1;
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_wdata       = '0;
        mem[16'h0040]       = c_line40;

        @(negedge clk);
        check16("rst_mem_resp", 16'(bus.mem_resp), 16'h0);
        check16("rst_pmem_read", 16'(bus.pmem_read), 16'h0);
        check16("rst_pmem_write", 16'(bus.pmem_write), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check16("idle_pmem_addr", bus.pmem_address, 16'h0);
        check16("idle_rdata", bus.mem_rdata, 16'h0);
        @(posedge clk);
        #1;

        // Cold miss, hits, word and high-byte writes in set 4.
        pm_push(1'b0, 16'h0040, '0);
        cpu_req(1'b0, 16'h0042, 2'b11, 16'h0000, 16'hBEEF, c_pmem_lat + 1);
        cpu_req(1'b0, 16'h0044, 2'b11, 16'h0000, 16'h2222, 0);
        cpu_req(1'b1, 16'h0040, 2'b11, 16'h1234, 16'h0000, 0);
        cpu_req(1'b1, 16'h0041, 2'b10, 16'hAB00, 16'h0000, 0);
        cpu_req(1'b0, 16'h0040, 2'b11, 16'h0000, 16'hAB34, 0);

        // Second way of set 4 (tag 1), clean allocate.
        pm_push(1'b0, 16'h00C0, '0);
        cpu_req(1'b1, 16'h00C0, 2'b11, 16'h5A5A, 16'h0000, c_pmem_lat + 1);

        // Tag 2 evicts dirty way 0 (tag 0), low-byte store.
        pm_push(1'b1, 16'h0040, set_word(c_line40, 0, 16'hAB34));
        pm_push(1'b0, 16'h0140, '0);
        cpu_req(1'b1, 16'h0140, 2'b01, 16'h0F0F, 16'h0000, 2 * c_pmem_lat + 1);
        cpu_req(1'b0, 16'h0140, 2'b11, 16'h0000, 16'h010F, 0);
        cpu_req(1'b0, 16'h0142, 2'b11, 16'h0000, 16'h0142, 0);

        // Tag 3 evicts LRU way 1 (tag 1).
        pm_push(1'b1, 16'h00C0, set_word(dflt_line(16'h00C0), 0, 16'h5A5A));
        pm_push(1'b0, 16'h01C0, '0);
        cpu_req(1'b0, 16'h01C0, 2'b11, 16'h0000, 16'h01C0, 2 * c_pmem_lat + 1);

        // Tag 0 returns from memory after evicting tag 2.
        pm_push(1'b1, 16'h0140, set_word(dflt_line(16'h0140), 0, 16'h010F));
        pm_push(1'b0, 16'h0040, '0);
        cpu_req(1'b0, 16'h0046, 2'b11, 16'h0000, 16'h3333, 2 * c_pmem_lat + 1);

        // Reset during ALLOCATE.
        bus.mem_address = 16'h0200;
        bus.mem_read    = 1'b1;
        n = 0;
        while (!bus.pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check16("alloc_started", 16'(bus.pmem_read), 16'h1);
        check16("alloc_addr", bus.pmem_address, 16'h0200);
        #2;
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        #1;
        check16("async_rst_pmem_read", 16'(bus.pmem_read), 16'h0);
        check16("async_rst_pmem_write", 16'(bus.pmem_write), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        pm_push(1'b0, 16'h0040, '0);
        cpu_req(1'b0, 16'h0042, 2'b11, 16'h0000, 16'hBEEF, c_pmem_lat + 1);

        // Request dropped mid-ALLOCATE: fill still lands, no mem_resp.
        pm_push(1'b0, 16'h0300, '0);
        bus.mem_address = 16'h0300;
        bus.mem_read    = 1'b1;
        n = 0;
        while (!bus.pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check16("drop_alloc_started", 16'(bus.pmem_read), 16'h1);
        @(posedge clk);
        #1;
        bus.mem_read    = 1'b0;
        bus.mem_address = 16'h0000;
        repeat (8) @(posedge clk);
        #1;
        check16("drop_fill_done", 16'(pm_q.size()), 16'h0);
        cpu_req(1'b0, 16'h0306, 2'b11, 16'h0000, 16'h0306, 0);

        @(negedge clk);
        check16("end_mem_resp", 16'(bus.mem_resp), 16'h0);
        check16("end_pmem_addr", bus.pmem_address, 16'h0);
        check16("end_resp_q", 16'(resp_q.size()), 16'h0);
        check16("end_pm_q", 16'(pm_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
